// File: rtl/bus_arbiter_m2_if.sv
// Control signals between the two bus masters, the split-capable slave and the arbiter.
interface bus_arbiter_m2_if;
  logic m1_breq;
  logic m2_breq;
  logic m1_bgrant;
  logic m2_bgrant;
  logic msel;
  logic m1_split;
  logic m2_split;
  logic split;
  logic split_ready;
  logic split_grant;
  logic bus_busy;

  // Arbiter side: takes requests and slave split status, drives grants.
  modport slave (
    input  m1_breq, m2_breq, split, split_ready,
    output m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant, bus_busy
  );

  // Requester side: masters and slave drive requests and split status.
  modport master (
    output m1_breq, m2_breq, split, split_ready,
    input  m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant, bus_busy
  );
endinterface

// File: rtl/bus_arbiter_m2.sv
// Two-master round-robin bus arbiter with single-outstanding split/resume support.
// All outputs are registered; one idle turnaround cycle separates bus owners.
module bus_arbiter_m2 #(
  parameter bit DEFAULT_PRIO = 1'b0,
  parameter bit SPLIT_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  bus_arbiter_m2_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, GNT1, GNT2, RESUME} state_t;

  state_t state_q, state_d;
  logic   g1_q, g1_d, g2_q, g2_d;
  logic   msel_q, msel_d;
  logic   s1_q, s1_d, s2_q, s2_d;
  logic   sg_q, sg_d;
  logic   busy_q;
  logic   last_q, last_d;

  logic   pend, owner, split_pulse, ready, e1, e2, owner_breq;

  // Split flags double as the pending split and its owner.
  assign pend        = s1_q | s2_q;
  assign owner       = s2_q;
  assign split_pulse = SPLIT_EN & bus.split;
  assign ready       = SPLIT_EN & bus.split_ready;
  assign e1          = bus.m1_breq & ~s1_q;
  assign e2          = bus.m2_breq & ~s2_q;
  // In RESUME the owner is the master currently selected onto the datapath.
  assign owner_breq  = msel_q ? bus.m2_breq : bus.m1_breq;

  always_comb begin
    state_d = state_q;
    g1_d    = 1'b0;
    g2_d    = 1'b0;
    msel_d  = msel_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    sg_d    = 1'b0;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pend && ready) begin
          state_d = RESUME;
          sg_d    = 1'b1;
          msel_d  = owner;
          last_d  = owner;
          g1_d    = ~owner;
          g2_d    = owner;
          s1_d    = 1'b0;
          s2_d    = 1'b0;
        end else if (e1 && (!e2 || last_q)) begin
          state_d = GNT1;
          g1_d    = 1'b1;
          msel_d  = 1'b0;
          last_d  = 1'b0;
        end else if (e2) begin
          state_d = GNT2;
          g2_d    = 1'b1;
          msel_d  = 1'b1;
          last_d  = 1'b1;
        end
      end
      GNT1: begin
        if (split_pulse && !pend) begin
          state_d = IDLE;
          s1_d    = 1'b1;
        end else if (bus.m1_breq) begin
          g1_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT2: begin
        if (split_pulse && !pend) begin
          state_d = IDLE;
          s2_d    = 1'b1;
        end else if (bus.m2_breq) begin
          g2_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RESUME: begin
        if (owner_breq) begin
          g1_d = ~msel_q;
          g2_d = msel_q;
          sg_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      msel_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      sg_q    <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= ~DEFAULT_PRIO;
    end else begin
      state_q <= state_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      msel_q  <= msel_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      sg_q    <= sg_d;
      busy_q  <= g1_d | g2_d;
      last_q  <= last_d;
    end
  end

  assign bus.m1_bgrant   = g1_q;
  assign bus.m2_bgrant   = g2_q;
  assign bus.msel        = msel_q;
  assign bus.m1_split    = s1_q;
  assign bus.m2_split    = s2_q;
  assign bus.split_grant = sg_q;
  assign bus.bus_busy    = busy_q;

endmodule
